bin2r4_encoder: RTL
===================

// Module: bin2r4_encoder
// PURPOSE
//  Sequential binary-to-radix-4 signed-digit encoder; the inverse of the divider's radix-4-to-binary converter.
//  Takes an unsigned binary mantissa (hidden bit included) and Booth-recodes it into NDIG digits in {-2..+2}.
//  Digits stream out MSD-first, one per cycle, with valid/ready backpressure. The packed 3*NDIG word is also presented.
//  Feeds the divider's digit-path test harness and the multiplier's radix-4 operand path.
// PARAMETERS
//  WIDTH  24            binary input width; must be even and >= 4
//  NDIG   WIDTH/2+1     digit count (13 for WIDTH=24); derived, not overridden
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-high reset
//  in_valid   in   1          input word valid
//  in_ready   out  1          encoder idle and can accept a word
//  in_data    in   WIDTH      unsigned binary mantissa
//  dig_valid  out  1          dig holds a valid digit
//  dig_ready  in   1          consumer accepts dig
//  dig        out  3          digit code: 0=000, +1=001, +2=010, -1=110, -2=101
//  dig_idx    out  $clog2(NDIG)  weight index i of current digit (value*4^i)
//  dig_last   out  1          high with digit index 0
//  word       out  3*NDIG     packed digits; digit i at [3i+2:3i]
//  word_valid out  1          one-cycle pulse: word complete and stable
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE; in_ready=1; dig_valid=0; dig=000; dig_idx=0; dig_last=0; word=0; word_valid=0.
//  Recoding: b extended with b[-1]=0 and b[WIDTH]=b[WIDTH+1]=0;
//   d_i = -2*b[2i+1] + b[2i] + b[2i-1], i=0..NDIG-1. Top digit is 0 or +1. Encodings 011,100,111 are never produced.
//  Invariant: sum(d_i*4^i) == in_data exactly.
//  FSM IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, compute all digits into word register, idx=NDIG-1 -> EMIT.
//  FSM EMIT: in_ready=0; dig_valid=1; dig=word[3*idx+2:3*idx]; dig_last=(idx==0).
//   dig_valid&&dig_ready: idx==0 -> IDLE, word_valid=1 for the next cycle only; otherwise idx decrements.
//   dig_valid&&!dig_ready: dig, dig_idx and dig_last hold stable; dig_valid stays high (no drop).
//  Latency: accept at edge t -> first digit valid after t; last handshake at edge t+NDIG with dig_ready held high.
//   word_valid is high in the following cycle. A new word is accepted at the earliest one cycle after return to IDLE.
//  word is held from latch until the next accepted input; it is not cleared on return to IDLE.
//  in_data is ignored while in_ready=0; no input buffering.
//  A mid-stream reset abandons the word; no digits and no word_valid follow until a new accept.
// STRUCTURE
//  Shared header radix4_defs.vh: digit code constants R4_ZERO/P1/P2/M1/M2 and the digit width (3).
//   Shared with the radix-4-to-binary converter and the SRT quotient logic.
//  Sub-module booth_r4_digit: combinational map from {b[2i+1],b[2i],b[2i-1]} to the 3-bit code.
//   NDIG instances are generated in parallel.
//  Top level: generate loop, 2-state FSM, down-counter idx, word register, word_valid pulse flop.
// TESTING (WIDTH=24)
//  1. in_data=0x000000, dig_ready=1 -> 13 digits of 000, dig_idx 12..0, dig_last on idx 0.
//     word=0, word_valid pulse after the last digit.
//  2. in_data=0x000003 -> d1=001, d0=110, others 000; word=39'o0000000000016 (octal, 1 digit = 3 bits).
//  3. in_data=0xFFFFFF -> d12=001, d11..d1=000, d0=110 (4^12-1).
//     in_data=0x800000 -> d12=001, d11=101, rest 000.
//  4. Backpressure: in_data=0x555555, dig_ready low for 3 cycles at idx 7.
//     -> dig/dig_idx stable and dig_valid high throughout; stream resumes at idx 7 with no digit lost or duplicated.
//  5. Reset asserted asynchronously at idx 5 -> outputs reach reset values before the next edge.
//     Then in_data=0x000001 yields d0=001 only.
//  6. Random 10k words with random dig_ready -> model sum(d_i*4^i)==in_data per word.
//     Only legal codes appear; in_ready never high while dig_valid high.

Source files
------------

// File: rtl/bin2r4_encoder_pkg.sv
// -----------------------------------------------------------------------------
// bin2r4_encoder_pkg
//   Shared radix-4 signed-digit definitions: digit width, the five digit codes,
//   the encoder FSM state type and the Booth radix-4 recoding function.
//   The same codes are used by the radix-4-to-binary converter and the SRT
//   quotient logic, so any change here changes the digit bus everywhere.
// -----------------------------------------------------------------------------
package bin2r4_encoder_pkg;

  // Width of one signed digit code on the digit bus.
  localparam int DIG_W = 3;

  // Digit codes. Sign-magnitude flavoured: bit 2 set means negative.
  // Codes 011, 100 and 111 are never produced.
  localparam logic [DIG_W-1:0] R4_ZERO = 3'b000;
  localparam logic [DIG_W-1:0] R4_P1   = 3'b001;
  localparam logic [DIG_W-1:0] R4_P2   = 3'b010;
  localparam logic [DIG_W-1:0] R4_M1   = 3'b110;
  localparam logic [DIG_W-1:0] R4_M2   = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_e;

  // Booth radix-4 recoding of one overlapping bit triple
  // {b[2i+1], b[2i], b[2i-1]} -> d_i = -2*b[2i+1] + b[2i] + b[2i-1].
  function automatic logic [DIG_W-1:0] booth_code(input logic [2:0] triple);
    logic [DIG_W-1:0] code;
    unique case (triple)
      3'b000:  code = R4_ZERO;
      3'b001:  code = R4_P1;
      3'b010:  code = R4_P1;
      3'b011:  code = R4_P2;
      3'b100:  code = R4_M2;
      3'b101:  code = R4_M1;
      3'b110:  code = R4_M1;
      default: code = R4_ZERO;  // 3'b111: -2 + 1 + 1
    endcase
    return code;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// -----------------------------------------------------------------------------
// booth_r4_digit
//   Combinational map from one overlapping Booth bit triple to a radix-4
//   signed-digit code. One instance per output digit.
// Ports:
//   triple  in   3      {b[2i+1], b[2i], b[2i-1]}
//   code    out  DIG_W  digit code (R4_ZERO/P1/P2/M1/M2)
// -----------------------------------------------------------------------------
module booth_r4_digit
  import bin2r4_encoder_pkg::*;
(
  input  logic [2:0]       triple,
  output logic [DIG_W-1:0] code
);

  assign code = booth_code(triple);

endmodule

// File: rtl/bin2r4_encoder.sv
// -----------------------------------------------------------------------------
// bin2r4_encoder
//   Sequential binary-to-radix-4 signed-digit encoder. An unsigned mantissa is
//   Booth-recoded into NDIG digits in {-2..+2} in one cycle at accept time;
//   the digits then stream out most-significant first, one per handshake,
//   under valid/ready flow control. The packed digit word is also presented
//   and a one-cycle word_valid pulse follows the last digit.
//   WIDTH must be even and >= 4; NDIG is derived and must not be overridden.
// Ports:
//   clk         in   1            rising-edge clock
//   rst         in   1            asynchronous active-high reset
//   in_valid    in   1            input word valid
//   in_ready    out  1            encoder idle, can accept a word
//   in_data     in   WIDTH        unsigned binary mantissa
//   dig_valid   out  1            dig holds a valid digit
//   dig_ready   in   1            consumer accepts dig
//   dig         out  3            digit code of weight 4^dig_idx
//   dig_idx     out  IDX_W        weight index of the current digit
//   dig_last    out  1            current digit is index 0
//   word        out  3*NDIG       packed digits, digit i at [3i+2:3i]
//   word_valid  out  1            one-cycle pulse after the last digit
// -----------------------------------------------------------------------------
module bin2r4_encoder
  import bin2r4_encoder_pkg::*;
#(
  parameter  int WIDTH = 24,
  localparam int NDIG  = WIDTH / 2 + 1,
  localparam int IDX_W = $clog2(NDIG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic [DIG_W-1:0]      dig,
  output logic [IDX_W-1:0]      dig_idx,
  output logic                  dig_last,
  output logic [DIG_W*NDIG-1:0] word,
  output logic                  word_valid
);

  // ---------------------------------------------------------------------------
  // Parallel recoding. ext[j] holds b[j-1]: a zero below the LSB for b[-1] and
  // two zeros above the MSB so the top digit sees {0, 0, b[WIDTH-1]}, which
  // keeps it non-negative (0 or +1) and makes the digit sum equal in_data.
  // ---------------------------------------------------------------------------
  logic [WIDTH+2:0]        ext;
  logic [DIG_W*NDIG-1:0]   codes;

  assign ext = {2'b00, in_data, 1'b0};

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    booth_r4_digit u_dig (
      .triple (ext[2*i+2 : 2*i]),
      .code   (codes[DIG_W*i +: DIG_W])
    );
  end

  // ---------------------------------------------------------------------------
  // Control: IDLE accepts a word, EMIT walks idx down from NDIG-1 to 0.
  // ---------------------------------------------------------------------------
  state_e                state, state_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic                  load;
  logic                  word_valid_nxt;
  logic [DIG_W*NDIG-1:0] word_q;
  logic                  word_valid_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // through the case leaves it unassigned, which would infer a latch.
    state_nxt      = state;
    idx_nxt        = idx;
    load           = 1'b0;
    word_valid_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          idx_nxt   = IDX_W'(NDIG - 1);
          state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (dig_ready) begin
          if (idx == '0) begin
            state_nxt      = ST_IDLE;
            word_valid_nxt = 1'b1;
          end else begin
            idx_nxt = idx - 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement or block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      idx          <= '0;
      word_valid_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      word_valid_q <= word_valid_nxt;
    end
  end

  // The word register is visible on the word port and must read zero after
  // reset, so unlike a pure datapath register it carries a reset. It is only
  // reloaded on accept and holds across the return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= codes;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are decoded from registers only, so an asynchronous reset takes
  // them to their reset values without waiting for a clock edge, and they are
  // naturally stable while the consumer stalls.
  // ---------------------------------------------------------------------------
  assign in_ready   = (state == ST_IDLE);
  assign dig_valid  = (state == ST_EMIT);
  assign dig        = dig_valid ? word_q[DIG_W*idx +: DIG_W] : R4_ZERO;
  assign dig_idx    = idx;
  assign dig_last   = dig_valid && (idx == '0);
  assign word       = word_q;
  assign word_valid = word_valid_q;

endmodule
